muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle multiply/divide engine in front of the ALU output converter.
- Accepts raw two's-complement operands plus a 5-bit ALU opcode.
- Performs the input-side conversion: sign extraction and absolute value per opcode signedness.
- Runs an unsigned 32-iteration shift-add multiply or restoring divide, then presents unsigned magnitudes and sign flags.
- The downstream output converter applies the final sign correction and result selection.

Parameters:
- XLEN, 32, operand/result width; only 32 supported.
- ITER_W, 6, iteration counter width; must hold values 0..XLEN.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- kill  in  1  pipeline flush; aborts any in-flight operation
- in_valid  in  1  request valid
- in_ready  out  1  engine idle, can accept
- opcode_i  in  5  ALU opcode
- src1_i  in  32  operand 1, raw
- src2_i  in  32  operand 2, raw
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- opcode_o  out  5  latched opcode for the output converter
- operator_1_o  out  1  sign flag 1 for the output converter
- operator_2_o  out  1  sign flag 2 for the output converter
- multiplier_o  out  64  unsigned product magnitude
- divider_q_o  out  32  quotient magnitude
- divider_r_o  out  32  remainder, final form

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low (rst_n).
- Reset state:
  - state=IDLE, in_ready=1, out_valid=0.
  - All data outputs 0; opcode_o=5'b00000; flags 0.
- Opcodes:
  - Multiply: 00010 MUL (s×s), 00011 MULH (s×s), 00100 MULHSU (s×u), 00101 MULHU (u×u).
  - Divide: 00110 DIV (s), 00111 DIVU, 01000 REM (s), 01001 REMU.
- Input conversion (combinational, on the accept cycle):
  - Each signed operand: sign = bit 31, magnitude = two's-complement absolute value (0x80000000 maps to 0x80000000).
  - Unsigned operands pass through unchanged with sign 0.
- Sign flags:
  - operator_1_o = src1 sign for MUL/MULH/MULHSU/DIV/REM, else 0.
  - operator_2_o = src2 sign for MUL/MULH/DIV/REM, else 0 (0 for MULHSU).
- Handshake:
  - Accept when in_valid & in_ready. Magnitudes, flags and opcode are latched on that edge.
  - in_ready = (state==IDLE).
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE→MUL: accept with opcode in 00010..00101.
  - IDLE→DIV: accept with opcode in 00110..01001.
  - IDLE→DONE: accept with any other opcode; all results 0, flags 0.
  - MUL/DIV→DONE: after 32 iterations, one iteration per cycle, counter 0..31.
  - DONE→IDLE: on out_valid & out_ready.
- Latency:
  - out_valid rises 32 cycles after the accept edge for mul/div, 1 cycle for illegal opcodes.
  - No back-to-back acceptance; the next accept is no earlier than the cycle after handshake completion.
- Multiply: radix-2 shift-add on magnitudes; full 64-bit product in multiplier_o; divider outputs 0.
- Divide:
  - Restoring divide on magnitudes; divider_q_o = quotient magnitude.
  - divider_r_o = remainder magnitude, negated when the op is REM and src1 was negative (sign follows dividend). The output converter passes the remainder unmodified.
  - multiplier_o = 0.
- Divide by zero (src2==0, DIV/DIVU/REM/REMU):
  - Still 32 cycles.
  - divider_q_o=0xFFFFFFFF; divider_r_o = raw src1.
  - operator_1_o=operator_2_o=0 forced, so the converter yields 0xFFFFFFFF.
- Signed overflow (0x80000000 / 0xFFFFFFFF):
  - Natural result q=0x80000000, r=0, flags 1,1; no special case.
- Output hold: in DONE with out_ready=0, all outputs are held stable.
- kill:
  - From any state, the next state is IDLE and out_valid drops on the next edge. Results are discarded; datapath registers need not clear.
  - kill has priority over accept and over the out handshake in the same cycle. While kill=1, in_ready is still 1 in IDLE but acceptance is suppressed.
- Reset mid-operation: immediate return to reset state.

Decomposition:
- Shared package (muldiv_pkg):
  - 5-bit opcode constants for the eight mul/div opcodes (same encoding as the ALU opcode space).
  - State encoding localparams.
  - Helper predicates is_mul / is_div / op1_signed / op2_signed.
- Sub-module md_operand_conv: combinational src→{sign, magnitude} per signedness. Instantiated twice.

Test Plan:
- DIV, src1=7, src2=0xFFFFFFFE (-2) → after 32 cycles: divider_q_o=3, divider_r_o=1, flags 0,1, opcode_o=00110.
- MUL, src1=0xFFFFFFFD (-3), src2=5 → multiplier_o=0x000000000000000F, flags 1,0. MULHSU with the same operands → flags 1,0.
- DIV, src1=0xFFFFFFF9, src2=0 → divider_q_o=0xFFFFFFFF, divider_r_o=0xFFFFFFF9, flags 0,0.
- DIV, src1=0x80000000, src2=0xFFFFFFFF → q=0x80000000, r=0, flags 1,1. REM with the same operands → r=0.
- Backpressure: MULHU 0xFFFFFFFF×0xFFFFFFFF with out_ready held low 5 cycles → multiplier_o=0xFFFFFFFE00000001 held stable, in_ready=0 throughout; handshake on the 6th cycle → IDLE next cycle.
- kill pulsed at iteration 10 of a DIV → IDLE next cycle, out_valid never asserts; a following DIVU 100/7 returns q=14, r=2.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Opcode encodings, FSM state encoding and opcode-class helpers shared by
// the sequential multiply/divide engine and its operand converters.
package muldiv_pkg;

  localparam logic [4:0] OP_MUL    = 5'b00010;
  localparam logic [4:0] OP_MULH   = 5'b00011;
  localparam logic [4:0] OP_MULHSU = 5'b00100;
  localparam logic [4:0] OP_MULHU  = 5'b00101;
  localparam logic [4:0] OP_DIV    = 5'b00110;
  localparam logic [4:0] OP_DIVU   = 5'b00111;
  localparam logic [4:0] OP_REM    = 5'b01000;
  localparam logic [4:0] OP_REMU   = 5'b01001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_MUL  = ST_MUL,
    S_DIV  = ST_DIV,
    S_DONE = ST_DONE
  } state_e;

  function automatic logic is_mul(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic op1_signed(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // MULHSU treats its second operand as unsigned.
  function automatic logic op2_signed(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle of the mul/div engine: request handshake plus flush
// on the way in, unsigned magnitudes and sign flags for the output converter.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic                kill;
  logic                in_valid;
  logic                in_ready;
  logic [4:0]          opcode_i;
  logic [XLEN-1:0]     src1_i;
  logic [XLEN-1:0]     src2_i;
  logic                out_valid;
  logic                out_ready;
  logic [4:0]          opcode_o;
  logic                operator_1_o;
  logic                operator_2_o;
  logic [2*XLEN-1:0]   multiplier_o;
  logic [XLEN-1:0]     divider_q_o;
  logic [XLEN-1:0]     divider_r_o;

  modport master (
    output kill, in_valid, opcode_i, src1_i, src2_i, out_ready,
    input  in_ready, out_valid, opcode_o, operator_1_o, operator_2_o,
           multiplier_o, divider_q_o, divider_r_o
  );

  modport slave (
    input  kill, in_valid, opcode_i, src1_i, src2_i, out_ready,
    output in_ready, out_valid, opcode_o, operator_1_o, operator_2_o,
           multiplier_o, divider_q_o, divider_r_o
  );

endinterface

// File: rtl/md_operand_conv.sv
// Combinational operand conversion: splits a raw operand into sign and
// magnitude when treated as signed, passes it through untouched otherwise.
module md_operand_conv #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] src_i,
  input  logic            signed_i,
  output logic            sign_o,
  output logic [XLEN-1:0] mag_o
);

  // The most negative value negates to itself, which is its correct
  // unsigned magnitude.
  always_comb begin
    sign_o = signed_i & src_i[XLEN-1];
    mag_o  = sign_o ? ('0 - src_i) : src_i;
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential 32-iteration shift-add multiply / restoring divide; out_valid 32
// cycles after accept (next cycle for unknown opcodes); results held until out_ready.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ITER_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  muldiv_seq_if.slave bus
);

  state_e              state_q, state_d;
  logic [ITER_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]     acc_hi_q, acc_hi_d;
  logic [XLEN-1:0]     acc_lo_q, acc_lo_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [XLEN-1:0]     raw1_q, raw1_d;
  logic                dz_q, dz_d;
  logic                rem_neg_q, rem_neg_d;
  logic [4:0]          opcode_q, opcode_d;
  logic                op1_q, op1_d;
  logic                op2_q, op2_d;
  logic                out_vld_q, out_vld_d;
  logic [2*XLEN-1:0]   mul_res_q, mul_res_d;
  logic [XLEN-1:0]     quo_q, quo_d;
  logic [XLEN-1:0]     rem_q, rem_d;

  logic                s1_sign, s2_sign;
  logic [XLEN-1:0]     s1_mag, s2_mag;
  logic                accept;
  logic                last_iter;
  logic                div_by_zero;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift;
  logic [XLEN:0]       div_diff;
  logic                div_bit;
  logic [XLEN-1:0]     div_rem_nxt;
  logic [XLEN-1:0]     div_quo_nxt;

  md_operand_conv #(.XLEN(XLEN)) u_conv1 (
    .src_i    (bus.src1_i),
    .signed_i (op1_signed(bus.opcode_i)),
    .sign_o   (s1_sign),
    .mag_o    (s1_mag)
  );

  md_operand_conv #(.XLEN(XLEN)) u_conv2 (
    .src_i    (bus.src2_i),
    .signed_i (op2_signed(bus.opcode_i)),
    .sign_o   (s2_sign),
    .mag_o    (s2_mag)
  );

  assign accept      = bus.in_valid && (state_q == S_IDLE) && !bus.kill;
  assign last_iter   = (cnt_q == ITER_W'(XLEN-1));
  assign div_by_zero = is_div(bus.opcode_i) && (bus.src2_i == '0);

  // Multiply: acc_hi:acc_lo starts as 0:multiplier and shifts right each step,
  // so after XLEN steps it holds the full product.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);

  // Divide: acc_hi is the partial remainder, acc_lo shifts the dividend out
  // of its top while quotient bits shift in at the bottom.
  assign div_shift   = {acc_hi_q, acc_lo_q[XLEN-1]};
  assign div_diff    = div_shift - {1'b0, opb_q};
  assign div_bit     = ~div_diff[XLEN];
  assign div_rem_nxt = div_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_quo_nxt = {acc_lo_q[XLEN-2:0], div_bit};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opb_d     = opb_q;
    raw1_d    = raw1_q;
    dz_d      = dz_q;
    rem_neg_d = rem_neg_q;
    opcode_d  = opcode_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    out_vld_d = out_vld_q;
    mul_res_d = mul_res_q;
    quo_d     = quo_q;
    rem_d     = rem_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          opcode_d  = bus.opcode_i;
          raw1_d    = bus.src1_i;
          cnt_d     = '0;
          dz_d      = div_by_zero;
          // Zeroed flags on divide-by-zero make the converter pass the all-ones quotient.
          op1_d     = s1_sign && !div_by_zero;
          op2_d     = s2_sign && !div_by_zero;
          rem_neg_d = (bus.opcode_i == OP_REM) && s1_sign;
          mul_res_d = '0;
          quo_d     = '0;
          rem_d     = '0;
          acc_hi_d  = '0;
          if (is_mul(bus.opcode_i)) begin
            acc_lo_d = s2_mag;
            opb_d    = s1_mag;
            state_d  = S_MUL;
          end else if (is_div(bus.opcode_i)) begin
            acc_lo_d = s1_mag;
            opb_d    = s2_mag;
            state_d  = S_DIV;
          end else begin
            state_d   = S_DONE;
            out_vld_d = 1'b1;
          end
        end
      end

      S_MUL: begin
        {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[XLEN-1:1]};
        cnt_d = cnt_q + ITER_W'(1);
        if (last_iter) begin
          mul_res_d = {mul_sum, acc_lo_q[XLEN-1:1]};
          state_d   = S_DONE;
          out_vld_d = 1'b1;
        end
      end

      S_DIV: begin
        acc_hi_d = div_rem_nxt;
        acc_lo_d = div_quo_nxt;
        cnt_d    = cnt_q + ITER_W'(1);
        if (last_iter) begin
          quo_d = dz_q ? '1 : div_quo_nxt;
          if (dz_q) begin
            rem_d = raw1_q;
          end else if (rem_neg_q) begin
            rem_d = '0 - div_rem_nxt;
          end else begin
            rem_d = div_rem_nxt;
          end
          state_d   = S_DONE;
          out_vld_d = 1'b1;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d   = S_IDLE;
          out_vld_d = 1'b0;
        end
      end

      default: begin
        state_d   = S_IDLE;
        out_vld_d = 1'b0;
      end
    endcase

    // Flush wins over both the request and the result handshake.
    if (bus.kill) begin
      state_d   = S_IDLE;
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opb_q     <= '0;
      raw1_q    <= '0;
      dz_q      <= 1'b0;
      rem_neg_q <= 1'b0;
      opcode_q  <= '0;
      op1_q     <= 1'b0;
      op2_q     <= 1'b0;
      out_vld_q <= 1'b0;
      mul_res_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opb_q     <= opb_d;
      raw1_q    <= raw1_d;
      dz_q      <= dz_d;
      rem_neg_q <= rem_neg_d;
      opcode_q  <= opcode_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      out_vld_q <= out_vld_d;
      mul_res_q <= mul_res_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
    end
  end

  assign bus.in_ready     = (state_q == S_IDLE);
  assign bus.out_valid    = out_vld_q;
  assign bus.opcode_o     = opcode_q;
  assign bus.operator_1_o = op1_q;
  assign bus.operator_2_o = op2_q;
  assign bus.multiplier_o = mul_res_q;
  assign bus.divider_q_o  = quo_q;
  assign bus.divider_r_o  = rem_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected results come from a plain
// integer-arithmetic model and are checked by an independent output monitor.
module tb_muldiv_seq;

  typedef struct {
    logic [4:0]  op;
    logic [63:0] mul;
    logic [31:0] q;
    logic [31:0] r;
    logic        f1;
    logic        f2;
    bit          muldiv;
    int          drv_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   rdy_mode = 0;
  exp_t sb_q[$];

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  // Reference model: signed operands are read as integers, the engine's
  // results are |a|*|b|, |a|/|b| and |a|%|b| with the sign rules applied.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb;
    longint unsigned ua, ub;
    bit s1, s2, is_m, is_d;
    s1   = (op == 5'd2) || (op == 5'd3) || (op == 5'd4) || (op == 5'd6) || (op == 5'd8);
    s2   = (op == 5'd2) || (op == 5'd3) || (op == 5'd6) || (op == 5'd8);
    is_m = (op >= 5'd2) && (op <= 5'd5);
    is_d = (op >= 5'd6) && (op <= 5'd9);
    sa = s1 ? longint'($signed(a)) : longint'(a);
    sb = s2 ? longint'($signed(b)) : longint'(b);
    ua = (sa < 0) ? longint'(-sa) : sa;
    ub = (sb < 0) ? longint'(-sb) : sb;
    e.op = op; e.mul = '0; e.q = '0; e.r = '0; e.f1 = 1'b0; e.f2 = 1'b0;
    e.muldiv = is_m || is_d;
    e.drv_cyc = 0;
    if (is_m) begin
      e.mul = ua * ub;
      e.f1  = (sa < 0);
      e.f2  = (sb < 0);
    end else if (is_d) begin
      if (b == 32'd0) begin
        e.q = 32'hFFFF_FFFF;
        e.r = a;
      end else begin
        e.q  = 32'(ua / ub);
        e.r  = 32'(ua % ub);
        if (op == 5'd8 && sa < 0) e.r = 32'(-longint'(ua % ub));
        e.f1 = (sa < 0);
        e.f2 = (sb < 0);
      end
    end
    return e;
  endfunction

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready) begin
      @(negedge clk);
      w++;
      if (w > 300) begin
        fail_now("issue_wait_in_ready");
        return;
      end
    end
    bus.in_valid = 1'b1;
    bus.opcode_i = op;
    bus.src1_i   = a;
    bus.src2_i   = b;
    e = model(op, a, b);
    e.drv_cyc = cyc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb_q.size() != 0) begin
      @(negedge clk);
      w++;
      if (w > 500) begin
        fail_now("drain");
        sb_q.delete();
        return;
      end
    end
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Consumer readiness: random, forced low, or forced high.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = ($urandom_range(0, 3) != 0);
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: latency on first sight of a result, stability while stalled,
  // full compare on the handshake.
  bit          seen = 0;
  logic [63:0] snap_mul;
  logic [63:0] snap_qr;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 0;
    end else if (bus.out_valid) begin
      if (!seen) begin
        seen = 1;
        snap_mul = bus.multiplier_o;
        snap_qr  = {bus.divider_q_o, bus.divider_r_o};
        if (sb_q.size() == 0) fail_now("unexpected_out_valid");
        else if (sb_q[0].muldiv) chk("latency", 64'(cyc - sb_q[0].drv_cyc - 1), 64'd32);
      end else begin
        chk("hold_mul", bus.multiplier_o, snap_mul);
        chk("hold_qr", {bus.divider_q_o, bus.divider_r_o}, snap_qr);
      end
      chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
      if (bus.out_ready) begin
        seen = 0;
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          chk("opcode_o", 64'(bus.opcode_o), 64'(e.op));
          chk("flags", 64'({bus.operator_1_o, bus.operator_2_o}), 64'({e.f1, e.f2}));
          chk("multiplier_o", bus.multiplier_o, e.mul);
          chk("divider_q_o", 64'(bus.divider_q_o), 64'(e.q));
          chk("divider_r_o", 64'(bus.divider_r_o), 64'(e.r));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  logic [4:0] ops [10];

  initial begin
    int w;
    ops = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd0, 5'd31};
    rst_n        = 1'b0;
    bus.kill     = 1'b0;
    bus.in_valid = 1'b0;
    bus.opcode_i = '0;
    bus.src1_i   = '0;
    bus.src2_i   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_opcode_o", 64'(bus.opcode_o), 64'd0);
    chk("rst_flags", 64'({bus.operator_1_o, bus.operator_2_o}), 64'd0);
    chk("rst_multiplier_o", bus.multiplier_o, 64'd0);
    chk("rst_qr", {bus.divider_q_o, bus.divider_r_o}, 64'd0);

    issue(5'd6, 32'd7, 32'hFFFF_FFFE);
    issue(5'd2, 32'hFFFF_FFFD, 32'd5);
    issue(5'd4, 32'hFFFF_FFFD, 32'd5);
    issue(5'd6, 32'hFFFF_FFF9, 32'd0);
    issue(5'd8, 32'hFFFF_FFF9, 32'd0);
    issue(5'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(5'd8, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(5'd8, 32'hFFFF_FFF9, 32'd2);
    issue(5'd10, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_drain();

    // Backpressure: result stalled 5 cycles, handshake on the 6th.
    rdy_mode = 1;
    @(posedge clk);
    issue(5'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.out_valid && w < 100);
    if (!bus.out_valid) fail_now("bp_wait_valid");
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid_held", 64'(bus.out_valid), 64'd1);
    end
    rdy_mode = 2;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_idle_out_valid", 64'(bus.out_valid), 64'd0);
    rdy_mode = 0;
    wait_drain();

    // Flush mid-divide.
    issue(5'd6, 32'h1234_5678, 32'd9);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.kill = 1'b1;
    sb_q.delete(sb_q.size() - 1);
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    @(negedge clk);
    chk("kill_in_ready", 64'(bus.in_ready), 64'd1);
    chk("kill_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (30) @(negedge clk);
    issue(5'd7, 32'd100, 32'd7);
    wait_drain();

    for (int i = 0; i < 60; i++) begin
      issue(ops[$urandom_range(0, 9)], rnd_opnd(), rnd_opnd());
    end
    wait_drain();

    // Reset in the middle of a multiply.
    issue(5'd3, 32'h7654_3210, 32'h0F0F_0F0F);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_opcode_o", 64'(bus.opcode_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(5'd9, 32'hFFFF_FFF9, 32'd4);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
